frame_sync_stream_mux: RTL and testbench

FRAME_SYNC_STREAM_MUX -- requirements
Module: frame_sync_stream_mux

---
 rtl/fsmux_pkg.sv | 14 +
 rtl/fsmux_lane_sel.sv | 49 ++++
 rtl/frame_sync_stream_mux.sv | 174 +++++++++++++++++
 tb/tb_frame_sync_stream_mux.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsmux_pkg.sv
// Shared definitions for the frame-synchronous stream multiplexer.
//   state_e     : controller states (RUN / SWITCH_WAIT / ALIGN)
//   FRAME_CNT_W : width of the emitted-frame counter
package fsmux_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SWITCH_WAIT = 2'd1,
    ALIGN       = 2'd2
  } state_e;

  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/fsmux_lane_sel.sv
// Combinational NUM_STREAMS:1 slice selector for pixel and timing lanes.
//   sel                          : stream index to pick
//   r_bus/g_bus/b_bus            : packed pixel channels, stream k at [k*PIX_W +: PIX_W]
//   hsync/vsync/lv/fv_bus        : per-stream timing, bit k = stream k
//   r/g/b, hsync/vsync/lv/fv     : selected stream's lanes (all zero for an out-of-range sel)
module fsmux_lane_sel #(
  parameter int NUM_STREAMS = 8,
  parameter int PIX_W       = 8,
  parameter int SEL_W       = $clog2(NUM_STREAMS)
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_STREAMS*PIX_W-1:0] r_bus,
  input  logic [NUM_STREAMS*PIX_W-1:0] g_bus,
  input  logic [NUM_STREAMS*PIX_W-1:0] b_bus,
  input  logic [NUM_STREAMS-1:0]       hsync_bus,
  input  logic [NUM_STREAMS-1:0]       vsync_bus,
  input  logic [NUM_STREAMS-1:0]       lv_bus,
  input  logic [NUM_STREAMS-1:0]       fv_bus,
  output logic [PIX_W-1:0]             r,
  output logic [PIX_W-1:0]             g,
  output logic [PIX_W-1:0]             b,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         lv,
  output logic                         fv
);

  always_comb begin
    r     = '0;
    g     = '0;
    b     = '0;
    hsync = 1'b0;
    vsync = 1'b0;
    lv    = 1'b0;
    fv    = 1'b0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      if (sel == SEL_W'(k)) begin
        r     = r_bus[k*PIX_W +: PIX_W];
        g     = g_bus[k*PIX_W +: PIX_W];
        b     = b_bus[k*PIX_W +: PIX_W];
        hsync = hsync_bus[k];
        vsync = vsync_bus[k];
        lv    = lv_bus[k];
        fv    = fv_bus[k];
      end
    end
  end

endmodule

// File: rtl/frame_sync_stream_mux.sv
// Frame-synchronous video stream multiplexer. Stream switches requested on
// iSel take effect only at the end of the active stream's frame, and output
// stays blank until the new stream starts a full frame.
//   iClk, iRst (async, active-low)
//   iSel                  : requested stream, ignored when >= NUM_STREAMS
//   iR/iG/iB, iHSync/iVSync/iLineValid/iFrameValid : packed per-stream inputs
//   oR/oG/oB, oHSync/oVSync/oLineValid/oFrameValid : registered selected stream
//   oActiveSel            : stream currently driving the outputs
//   oSwitchPending        : high in SWITCH_WAIT and ALIGN
//   oFrameCount           : count of emitted frames (falling edges of oFrameValid)
module frame_sync_stream_mux
  import fsmux_pkg::*;
#(
  parameter int NUM_STREAMS = 8,
  parameter int PIX_W       = 8,
  parameter int SEL_W       = $clog2(NUM_STREAMS)
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [SEL_W-1:0]             iSel,
  input  logic [NUM_STREAMS*PIX_W-1:0] iR,
  input  logic [NUM_STREAMS*PIX_W-1:0] iG,
  input  logic [NUM_STREAMS*PIX_W-1:0] iB,
  input  logic [NUM_STREAMS-1:0]       iHSync,
  input  logic [NUM_STREAMS-1:0]       iVSync,
  input  logic [NUM_STREAMS-1:0]       iLineValid,
  input  logic [NUM_STREAMS-1:0]       iFrameValid,
  output logic [PIX_W-1:0]             oR,
  output logic [PIX_W-1:0]             oG,
  output logic [PIX_W-1:0]             oB,
  output logic                         oHSync,
  output logic                         oVSync,
  output logic                         oLineValid,
  output logic                         oFrameValid,
  output logic [SEL_W-1:0]             oActiveSel,
  output logic                         oSwitchPending,
  output logic [FRAME_CNT_W-1:0]       oFrameCount
);

  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_STREAMS);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       active_sel_q, active_sel_d;
  logic [SEL_W-1:0]       pend_sel_q, pend_sel_d;
  logic                   fv_hist_q, fv_hist_d;
  logic [PIX_W-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   hs_q, hs_d, vs_q, vs_d, lv_q, lv_d, fv_q, fv_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [PIX_W-1:0] sel_r, sel_g, sel_b;
  logic             sel_hs, sel_vs, sel_lv, sel_fv;
  logic             sel_valid, fv_rise, fv_fall;

  fsmux_lane_sel #(
    .NUM_STREAMS (NUM_STREAMS),
    .PIX_W       (PIX_W),
    .SEL_W       (SEL_W)
  ) u_lane_sel (
    .sel       (active_sel_q),
    .r_bus     (iR),
    .g_bus     (iG),
    .b_bus     (iB),
    .hsync_bus (iHSync),
    .vsync_bus (iVSync),
    .lv_bus    (iLineValid),
    .fv_bus    (iFrameValid),
    .r         (sel_r),
    .g         (sel_g),
    .b         (sel_b),
    .hsync     (sel_hs),
    .vsync     (sel_vs),
    .lv        (sel_lv),
    .fv        (sel_fv)
  );

  always_comb begin
    sel_valid = {1'b0, iSel} < SEL_LIMIT;
    fv_rise   = sel_fv & ~fv_hist_q;
    fv_fall   = ~sel_fv & fv_hist_q;

    state_d      = state_q;
    active_sel_d = active_sel_q;
    pend_sel_d   = pend_sel_q;
    fv_hist_d    = sel_fv;
    r_d  = sel_r;
    g_d  = sel_g;
    b_d  = sel_b;
    hs_d = sel_hs;
    vs_d = sel_vs;
    lv_d = sel_lv;
    fv_d = sel_fv;

    unique case (state_q)
      RUN: begin
        if (sel_valid && (iSel != active_sel_q)) begin
          pend_sel_d = iSel;
          state_d    = SWITCH_WAIT;
        end
      end
      SWITCH_WAIT: begin
        if (sel_valid && (iSel == active_sel_q)) begin
          state_d = RUN;
        end else begin
          if (sel_valid) pend_sel_d = iSel;
          if (fv_fall) begin
            active_sel_d = pend_sel_d;
            // Seed history with the incoming stream's current level so the
            // first cycle on the new stream cannot see a spurious edge.
            fv_hist_d    = iFrameValid[pend_sel_d];
            state_d      = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (fv_rise) begin
          state_d = RUN;
        end else begin
          r_d  = '0;
          g_d  = '0;
          b_d  = '0;
          lv_d = 1'b0;
          fv_d = 1'b0;
        end
      end
      default: state_d = ALIGN;
    endcase

    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(fv_q & ~fv_d);
  end

  // History resets high so a stream already mid-frame at reset release is
  // not mistaken for a frame start.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q      <= ALIGN;
      active_sel_q <= '0;
      pend_sel_q   <= '0;
      fv_hist_q    <= 1'b1;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      lv_q         <= 1'b0;
      fv_q         <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      pend_sel_q   <= pend_sel_d;
      fv_hist_q    <= fv_hist_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      lv_q         <= lv_d;
      fv_q         <= fv_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign oR             = r_q;
  assign oG             = g_q;
  assign oB             = b_q;
  assign oHSync         = hs_q;
  assign oVSync         = vs_q;
  assign oLineValid     = lv_q;
  assign oFrameValid    = fv_q;
  assign oActiveSel     = active_sel_q;
  assign oSwitchPending = (state_q != RUN);
  assign oFrameCount    = frame_cnt_q;

endmodule

// File: tb/tb_frame_sync_stream_mux.sv
module tb_frame_sync_stream_mux;

  localparam int NS = 6;
  localparam int PW = 8;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic [2:0]    iSel = '0;
  logic [NS*PW-1:0] iR = '0, iG = '0, iB = '0;
  logic [NS-1:0] iHSync = '0, iVSync = '0, iLineValid = '0, iFrameValid = '0;
  logic [PW-1:0] oR, oG, oB;
  logic          oHSync, oVSync, oLineValid, oFrameValid, oSwitchPending;
  logic [2:0]    oActiveSel;
  logic [15:0]   oFrameCount;

  frame_sync_stream_mux #(
    .NUM_STREAMS (NS),
    .PIX_W       (PW)
  ) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iSel           (iSel),
    .iR             (iR),
    .iG             (iG),
    .iB             (iB),
    .iHSync         (iHSync),
    .iVSync         (iVSync),
    .iLineValid     (iLineValid),
    .iFrameValid    (iFrameValid),
    .oR             (oR),
    .oG             (oG),
    .oB             (oB),
    .oHSync         (oHSync),
    .oVSync         (oVSync),
    .oLineValid     (oLineValid),
    .oFrameValid    (oFrameValid),
    .oActiveSel     (oActiveSel),
    .oSwitchPending (oSwitchPending),
    .oFrameCount    (oFrameCount)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        hs, vs, lv, fv;
    logic [2:0]  sel;
    logic        pend;
    logic [15:0] cnt;
  } out_t;

  // One stimulus cycle: input sel / per-stream FrameValid (LineValid mirrors it),
  // plus the expected registered outputs one cycle later.
  typedef struct {
    logic [2:0]  sel;
    logic [5:0]  fv;
    logic [2:0]  e_sel;
    logic        e_pend;
    logic        e_fv;
    logic [2:0]  e_src;   // stream whose hsync/vsync/pixels appear
    logic        e_blank; // pixels and LV forced to zero
    logic [15:0] e_cnt;
  } vec_t;

  out_t got_w;
  assign got_w = {oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid,
                  oActiveSel, oSwitchPending, oFrameCount};

  int   checks   = 0;
  int   failures = 0;
  int   vi       = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(int sel, int fv, int e_sel, int e_pend, int e_fv,
                              int e_src, int e_blank, int e_cnt);
    vec_t v;
    v.sel = 3'(sel);    v.fv = 6'(fv);       v.e_sel = 3'(e_sel);
    v.e_pend = 1'(e_pend); v.e_fv = 1'(e_fv); v.e_src = 3'(e_src);
    v.e_blank = 1'(e_blank); v.e_cnt = 16'(e_cnt);
    return v;
  endfunction

  // Non-zero per-cycle, per-stream, per-channel pixel value.
  function automatic logic [7:0] pix(int v, int k, int ch);
    return 8'(v * 16 + k * 2 + ch * 64 + 1);
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    out_t e;
    out_t g;
    logic [5:0] hsm, vsm;
    @(negedge iClk);
    hsm = 6'(vi * 5);
    vsm = 6'(vi * 3);
    iSel        = v.sel;
    iFrameValid = v.fv;
    iLineValid  = v.fv;
    iHSync      = hsm;
    iVSync      = vsm;
    for (int k = 0; k < NS; k++) begin
      iR[k*PW +: PW] = pix(vi, k, 0);
      iG[k*PW +: PW] = pix(vi, k, 1);
      iB[k*PW +: PW] = pix(vi, k, 2);
    end
    e.r    = v.e_blank ? 8'h00 : pix(vi, int'(v.e_src), 0);
    e.g    = v.e_blank ? 8'h00 : pix(vi, int'(v.e_src), 1);
    e.b    = v.e_blank ? 8'h00 : pix(vi, int'(v.e_src), 2);
    e.hs   = hsm[v.e_src];
    e.vs   = vsm[v.e_src];
    e.lv   = v.e_fv;
    e.fv   = v.e_fv;
    e.sel  = v.e_sel;
    e.pend = v.e_pend;
    e.cnt  = v.e_cnt;
    sb.push_back(e);
    @(posedge iClk);
    #1;
    g = got_w;
    e = sb.pop_front();
    check_out($sformatf("%s[%0d]", name, vi), g, e);
    vi++;
  endtask

  initial begin
    // sel, fv mask, exp sel, exp pend, exp fv, exp src, exp blank, exp count
    tbl.push_back(mk(0, 'h01, 0, 1, 0, 0, 1, 0)); // reset released mid-frame: blank
    tbl.push_back(mk(0, 'h01, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 'h00, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 'h01, 0, 0, 1, 0, 0, 0)); // first full frame start passes
    tbl.push_back(mk(0, 'h01, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 'h01, 0, 1, 1, 0, 0, 0)); // request 3 mid-frame
    tbl.push_back(mk(3, 'h09, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(3, 'h08, 3, 1, 0, 0, 0, 1)); // stream 0 ends -> active 3
    tbl.push_back(mk(3, 'h08, 3, 1, 0, 3, 1, 1)); // stream 3 mid-frame: blank
    tbl.push_back(mk(3, 'h00, 3, 1, 0, 3, 1, 1));
    tbl.push_back(mk(3, 'h08, 3, 0, 1, 3, 0, 1)); // stream 3 frame start
    tbl.push_back(mk(3, 'h08, 3, 0, 1, 3, 0, 1));
    tbl.push_back(mk(5, 'h08, 3, 1, 1, 3, 0, 1)); // 5 -> 1 -> back to 3 cancels
    tbl.push_back(mk(1, 'h08, 3, 1, 1, 3, 0, 1));
    tbl.push_back(mk(3, 'h08, 3, 0, 1, 3, 0, 1));
    tbl.push_back(mk(7, 'h08, 3, 0, 1, 3, 0, 1)); // out-of-range selects ignored
    tbl.push_back(mk(6, 'h08, 3, 0, 1, 3, 0, 1));
    tbl.push_back(mk(3, 'h00, 3, 0, 0, 3, 0, 2));
    tbl.push_back(mk(3, 'h00, 3, 0, 0, 3, 0, 2));
    tbl.push_back(mk(3, 'h08, 3, 0, 1, 3, 0, 2));
    tbl.push_back(mk(0, 'h08, 3, 1, 1, 3, 0, 2)); // request 0
    tbl.push_back(mk(7, 'h08, 3, 1, 1, 3, 0, 2)); // invalid in SWITCH_WAIT: no cancel
    tbl.push_back(mk(0, 'h01, 0, 1, 0, 3, 0, 3)); // 3 falls while 0 rises
    tbl.push_back(mk(0, 'h01, 0, 1, 0, 0, 1, 3)); // no edge seen: still blank
    tbl.push_back(mk(0, 'h00, 0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 'h01, 0, 0, 1, 0, 0, 3)); // next stream-0 frame start
    tbl.push_back(mk(2, 'h01, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 4)); // cancel + fall same cycle: cancel
    tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 4));

    // Reset held with stream 0 mid-frame.
    iFrameValid = 6'h01;
    iLineValid  = 6'h01;
    iHSync      = '1;
    iVSync      = '1;
    iR = '1; iG = '1; iB = '1;
    repeat (2) @(posedge iClk);
    #1;
    check_out("reset_state", got_w, out_t'({8'h00, 8'h00, 8'h00, 4'b0000, 3'd0, 1'b1, 16'h0000}));
    @(negedge iClk);
    iRst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "vec");

    // Mid-frame asynchronous reset truncates output without counting.
    run_vec(mk(0, 'h01, 0, 0, 1, 0, 0, 4), "pre_rst");
    run_vec(mk(0, 'h01, 0, 0, 1, 0, 0, 4), "pre_rst");
    @(negedge iClk);
    #2;
    iRst = 1'b0;
    #1;
    check_out("async_reset", got_w, out_t'({8'h00, 8'h00, 8'h00, 4'b0000, 3'd0, 1'b1, 16'h0000}));
    @(posedge iClk);
    #1;
    check_cnt("reset_cnt_hold", oFrameCount, 16'h0000);
    @(negedge iClk);
    iRst = 1'b1;
    run_vec(mk(0, 'h01, 0, 1, 0, 0, 1, 0), "post_rst");
    run_vec(mk(0, 'h00, 0, 1, 0, 0, 1, 0), "post_rst");
    run_vec(mk(0, 'h01, 0, 0, 1, 0, 0, 0), "post_rst");
    run_vec(mk(0, 'h00, 0, 0, 0, 0, 0, 1), "post_rst");

    // Counter wrap: preload near the top, then emit two short frames.
    @(negedge iClk);
    force dut.frame_cnt_q = 16'hFFFE;
    @(posedge iClk);
    #1;
    release dut.frame_cnt_q;
    check_cnt("cnt_preload", oFrameCount, 16'hFFFE);
    run_vec(mk(0, 'h01, 0, 0, 1, 0, 0, 'hFFFE), "wrap");
    run_vec(mk(0, 'h00, 0, 0, 0, 0, 0, 'hFFFF), "wrap");
    run_vec(mk(0, 'h01, 0, 0, 1, 0, 0, 'hFFFF), "wrap");
    run_vec(mk(0, 'h00, 0, 0, 0, 0, 0, 'h0000), "wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
